// File: rtl/rate_tick_sched.sv
// rate_tick_sched
// Sampling-rate scheduler for the 4 MHz base-clock domain. Drives a 3-bit
// rate code into an external combinational decoder and divides the base
// clock by the returned terminal count to produce a one-cycle sample tick.
// The scheduler runs finite bursts or continuous operation. Rate changes
// requested while running are held and applied only on a tick boundary, so
// every sample period runs in full at a single rate.
//
// Ports:
//   clk        base clock
//   reset      synchronous, active-low reset
//   start      one-cycle burst request (IDLE only)
//   stop       one-cycle abort request (RUN only)
//   burst_len  ticks per burst, latched on start; 0 = continuous
//   sel_in     requested rate code; sel_valid/sel_ready handshake
//   rate_sel   registered rate code to the decoder
//   rate_tc    terminal count returned by the decoder
//   tick       one-cycle sample strobe
//   tick_cnt   ticks issued in the current burst
//   busy       high while running
//   done       one-cycle pulse when a finite burst completes
module rate_tick_sched #(
  parameter int         CNT_W     = 24,
  parameter int         BURST_W   = 16,
  parameter logic [2:0] RESET_SEL = 3'b000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [2:0]         sel_in,
  input  logic               sel_valid,
  output logic               sel_ready,
  output logic [2:0]         rate_sel,
  input  logic [CNT_W-1:0]   rate_tc,
  output logic               tick,
  output logic [BURST_W-1:0] tick_cnt,
  output logic               busy,
  output logic               done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q,     state_d;
  logic [2:0]         rate_sel_q,  rate_sel_d;
  logic [2:0]         pend_sel_q,  pend_sel_d;
  logic               pend_q,      pend_d;
  logic               sel_ready_q, sel_ready_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               tick_q,      tick_d;
  logic [BURST_W-1:0] tick_cnt_q,  tick_cnt_d;
  logic [BURST_W-1:0] burst_len_q, burst_len_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;

  logic               sel_hs;
  logic               tc_hit;
  logic [BURST_W-1:0] tick_cnt_inc;
  logic               last_tick;
  logic               leave_run;

  assign sel_hs       = sel_valid && sel_ready_q;
  // >= rather than == so a rate change to a shorter tc can never strand cnt
  // above the new terminal count.
  assign tc_hit       = (cnt_q >= rate_tc);
  assign tick_cnt_inc = tick_cnt_q + 1'b1;
  assign last_tick    = (burst_len_q != '0) && (tick_cnt_inc == burst_len_q);

  always_comb begin
    state_d     = state_q;
    rate_sel_d  = rate_sel_q;
    pend_sel_d  = pend_sel_q;
    pend_d      = pend_q;
    sel_ready_d = sel_ready_q;
    cnt_d       = cnt_q;
    tick_d      = 1'b0;
    tick_cnt_d  = tick_cnt_q;
    burst_len_d = burst_len_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    leave_run   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_hs) begin
          rate_sel_d = sel_in;
        end
        // stop has priority over a simultaneous start
        if (start && !stop) begin
          state_d     = S_RUN;
          cnt_d       = '0;
          tick_cnt_d  = '0;
          burst_len_d = burst_len;
          busy_d      = 1'b1;
        end
      end

      S_RUN: begin
        if (stop) begin
          // Abort suppresses any coincident tick; tick_cnt is kept.
          leave_run = 1'b1;
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          cnt_d     = '0;
        end else if (tc_hit) begin
          tick_d     = 1'b1;
          cnt_d      = '0;
          tick_cnt_d = tick_cnt_inc;
          if (last_tick) begin
            leave_run = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
            busy_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        // A held rate takes effect on a tick edge or when leaving RUN.
        if (pend_q && (tc_hit || leave_run)) begin
          rate_sel_d  = pend_sel_q;
          pend_d      = 1'b0;
          sel_ready_d = 1'b1;
        end

        // sel_hs implies pend_q==0, so this never collides with the apply
        // above. A code accepted on the edge that leaves RUN has no later
        // tick to wait for, so it is loaded directly as in IDLE.
        if (sel_hs) begin
          if (leave_run) begin
            rate_sel_d = sel_in;
          end else begin
            pend_sel_d  = sel_in;
            pend_d      = 1'b1;
            sel_ready_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rate_sel_q  <= RESET_SEL;
      pend_sel_q  <= RESET_SEL;
      pend_q      <= 1'b0;
      sel_ready_q <= 1'b1;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      tick_cnt_q  <= '0;
      burst_len_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_sel_q  <= rate_sel_d;
      pend_sel_q  <= pend_sel_d;
      pend_q      <= pend_d;
      sel_ready_q <= sel_ready_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      tick_cnt_q  <= tick_cnt_d;
      burst_len_q <= burst_len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sel_ready = sel_ready_q;
  assign rate_sel  = rate_sel_q;
  assign tick      = tick_q;
  assign tick_cnt  = tick_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rate_tick_sched.sv
// tb_rate_tick_sched
// Directed bench for rate_tick_sched with a behavioural model of the rate
// decoder. BURST_W is 4 so tick_cnt wraparound is reachable quickly.
module tb_rate_tick_sched;

  localparam int CNT_W   = 24;
  localparam int BURST_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               stop;
  logic [BURST_W-1:0] burst_len;
  logic [2:0]         sel_in;
  logic               sel_valid;
  logic               sel_ready;
  logic [2:0]         rate_sel;
  logic [CNT_W-1:0]   rate_tc;
  logic               tick;
  logic [BURST_W-1:0] tick_cnt;
  logic               busy;
  logic               done;

  int passed     = 0;
  int total      = 0;
  int done_cnt   = 0;
  int tick_seen  = 0;

  rate_tick_sched #(
    .CNT_W    (CNT_W),
    .BURST_W  (BURST_W),
    .RESET_SEL(3'b000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .burst_len(burst_len),
    .sel_in   (sel_in),
    .sel_valid(sel_valid),
    .sel_ready(sel_ready),
    .rate_sel (rate_sel),
    .rate_tc  (rate_tc),
    .tick     (tick),
    .tick_cnt (tick_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Rate decoder model
  always_comb begin
    rate_tc = 24'd4;
    case (rate_sel)
      3'd0: rate_tc = 24'd4;
      3'd1: rate_tc = 24'd9;
      3'd2: rate_tc = 24'd24;
      3'd3: rate_tc = 24'd49;
      3'd4: rate_tc = 24'd99;
      3'd5: rate_tc = 24'd249;
      3'd6: rate_tc = 24'd499;
      3'd7: rate_tc = 24'd999;
      default: rate_tc = 24'd4;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
    if (tick === 1'b1) tick_seen++;
  endtask

  // Count edges until the next tick; returns limit on timeout.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < limit);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int t0;
    int d0;
    logic [31:0] tmask;
    logic [31:0] dmask;
    logic [31:0] exp_mask;

    reset = 1'b0; start = 1'b0; stop = 1'b0;
    burst_len = '0; sel_in = 3'd0; sel_valid = 1'b0;

    // ---- Reset and idle ----
    repeat (3) step();
    check("rst_rate_sel", 32'(rate_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sel_ready", 32'(sel_ready), 1);
    check("rst_tick", 32'(tick), 0);
    check("rst_tick_cnt", 32'(tick_cnt), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b1;
    t0 = tick_seen;
    repeat (50) step();
    check("idle_no_tick", 32'(tick_seen - t0), 0);
    $display("step reset/idle done");

    // ---- Basic burst: sel 1 (tc=9), 3 ticks ----
    sel_in = 3'd1; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    check("burst_rate_sel", 32'(rate_sel), 1);
    start = 1'b1; burst_len = 4'd3;
    step();
    start = 1'b0;
    check("burst_busy", 32'(busy), 1);
    check("burst_tick_cnt0", 32'(tick_cnt), 0);
    tmask = '0; dmask = '0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (tick === 1'b1) tmask[k] = 1'b1;
      if (done === 1'b1) dmask[k] = 1'b1;
    end
    exp_mask = 32'h4010_0400;  // bits 10, 20, 30
    check("burst_tick_pos", tmask, exp_mask);
    exp_mask = 32'h4000_0000;  // bit 30 only
    check("burst_done_pos", dmask, exp_mask);
    check("burst_end_busy", 32'(busy), 0);
    check("burst_end_cnt", 32'(tick_cnt), 3);
    step();
    check("burst_after_tick", 32'(tick), 0);
    check("burst_after_done", 32'(done), 0);
    check("burst_after_busy", 32'(busy), 0);
    check("burst_after_cnt", 32'(tick_cnt), 3);
    $display("step basic burst done");

    // ---- Change mid-run: sel 0 -> sel 2 at cnt=2 ----
    sel_in = 3'd0; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    start = 1'b1; burst_len = 4'd0;
    step();
    start = 1'b0;
    step(); step();             // cnt = 2
    sel_in = 3'd2; sel_valid = 1'b1;
    step();                     // handshake, cnt = 3
    sel_valid = 1'b0;
    check("chg_ready_low", 32'(sel_ready), 0);
    check("chg_rate_held", 32'(rate_sel), 0);
    step();                     // cnt = 4
    check("chg_ready_low2", 32'(sel_ready), 0);
    step();                     // first tick, new rate applied
    check("chg_tick", 32'(tick), 1);
    check("chg_rate_new", 32'(rate_sel), 2);
    check("chg_ready_back", 32'(sel_ready), 1);
    wait_tick(2000, n);
    check("chg_period1", n, 25);
    wait_tick(2000, n);
    check("chg_period2", n, 25);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("chg_stop_busy", 32'(busy), 0);
    $display("step rate change done");

    // ---- Sel handshake on terminal-count cycle ----
    sel_in = 3'd0; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    start = 1'b1; burst_len = 4'd0;
    step();
    start = 1'b0;
    wait_tick(2000, n);
    check("tc_first_period", n, 5);
    repeat (4) step();          // cnt = 4
    sel_in = 3'd3; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    check("tc_tick", 32'(tick), 1);
    check("tc_ready_low", 32'(sel_ready), 0);
    check("tc_rate_held", 32'(rate_sel), 0);
    wait_tick(2000, n);
    check("tc_old_period", n, 5);
    check("tc_rate_new", 32'(rate_sel), 3);
    wait_tick(2000, n);
    check("tc_new_period1", n, 50);
    wait_tick(2000, n);
    check("tc_new_period2", n, 50);
    check("tc_tick_cnt", 32'(tick_cnt), 5);
    $display("step sel on terminal count done");

    // ---- Stop on terminal-count cycle ----
    repeat (49) step();         // cnt = 49 = tc
    check("stop_pre_tick", 32'(tick), 0);
    d0 = done_cnt;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_tick", 32'(tick), 0);
    check("stop_done", 32'(done), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_tick_cnt", 32'(tick_cnt), 5);
    step();
    check("stop_idle_tick", 32'(tick), 0);
    check("stop_no_done", 32'(done_cnt - d0), 0);
    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; burst_len = 4'd2;
    step();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 0);
    t0 = tick_seen;
    repeat (10) step();
    check("startstop_no_tick", 32'(tick_seen - t0), 0);
    $display("step stop/simultaneous done");

    // ---- Reset mid-burst at sel 7 ----
    sel_in = 3'd7; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    check("mid_rate_sel7", 32'(rate_sel), 7);
    start = 1'b1; burst_len = 4'd2;
    step();
    start = 1'b0;
    d0 = done_cnt;
    repeat (20) step();
    check("mid_busy", 32'(busy), 1);
    reset = 1'b0;
    step();
    check("mid_rst_rate_sel", 32'(rate_sel), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_sel_ready", 32'(sel_ready), 1);
    check("mid_rst_tick", 32'(tick), 0);
    check("mid_rst_tick_cnt", 32'(tick_cnt), 0);
    check("mid_rst_done", 32'(done), 0);
    reset = 1'b1;
    repeat (5) step();
    check("mid_no_done", 32'(done_cnt - d0), 0);
    check("mid_still_idle", 32'(busy), 0);
    $display("step reset mid-burst done");

    // ---- Continuous wrap of tick_cnt at sel 0 ----
    start = 1'b1; burst_len = 4'd0;
    step();
    start = 1'b0;
    d0 = done_cnt;
    for (int i = 1; i <= 17; i++) begin
      wait_tick(2000, n);
      if (i == 1)  check("wrap_period", n, 5);
      if (i == 15) check("wrap_cnt15", 32'(tick_cnt), 15);
      if (i == 16) check("wrap_cnt0", 32'(tick_cnt), 0);
      if (i == 17) check("wrap_cnt1", 32'(tick_cnt), 1);
    end
    check("wrap_no_done", 32'(done_cnt - d0), 0);
    check("wrap_busy", 32'(busy), 1);
    $display("step wrap done");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
